// File: rtl/md_unit.sv
// md_unit: multi-cycle multiply/divide unit owning the HI/LO registers.
// Results are computed from the operands sampled at the start edge and
// held in pending registers. They reach HI/LO only when the fixed-latency
// countdown expires, so the rest of the pipeline sees a real multi-cycle unit.
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MD_start,
  input  logic [2:0]  MD_op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  // Counter must hold the largest latency and is never narrower than 4 bits.
  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_BITS   = $clog2(MAX_CYCLES + 1);
  localparam int CW         = (CNT_BITS > 4) ? CNT_BITS : 4;

  localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES);
  localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t        state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [31:0]   hi_reg, hi_next;
  logic [31:0]   lo_reg, lo_next;
  logic [31:0]   pend_hi_reg, pend_hi_next;
  logic [31:0]   pend_lo_reg, pend_lo_next;
  // Set when the pending result is allowed to reach HI/LO; clear for a
  // divide by zero, which burns the full latency but leaves HI/LO alone.
  logic          commit_en_reg, commit_en_next;
  logic          busy_reg, busy_next;

  // ---------------------------------------------------------------------
  // Arithmetic on the live operands; only consumed at the start edge.
  // ---------------------------------------------------------------------
  logic [63:0] prod_signed;
  logic [63:0] prod_unsigned;
  logic        b_zero;
  logic [31:0] b_safe;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] mag_q;
  logic [31:0] mag_r;
  logic [31:0] sdiv_q;
  logic [31:0] sdiv_r;
  logic [31:0] udiv_q;
  logic [31:0] udiv_r;

  // Sign-extending to 64 bits makes the truncated 64-bit product the exact
  // two's-complement signed product.
  assign prod_signed   = {{32{A[31]}}, A} * {{32{B[31]}}, B};
  assign prod_unsigned = {32'd0, A} * {32'd0, B};

  // A zero divisor is replaced so the dividers never see it; the result is
  // discarded anyway because commit is suppressed.
  assign b_zero = (B == 32'd0);
  assign b_safe = b_zero ? 32'd1 : B;

  // Signed divide via magnitudes. |0x80000000| is 0x80000000 as an unsigned
  // value, so the overflow case 0x80000000 / -1 naturally yields
  // quotient 0x80000000 and remainder 0 without special handling.
  assign a_mag = A[31] ? (~A + 32'd1) : A;
  assign b_mag = b_safe[31] ? (~b_safe + 32'd1) : b_safe;
  assign mag_q = a_mag / b_mag;
  assign mag_r = a_mag % b_mag;

  // Quotient truncates toward zero; remainder follows the dividend's sign.
  assign sdiv_q = (A[31] ^ B[31]) ? (~mag_q + 32'd1) : mag_q;
  assign sdiv_r = A[31] ? (~mag_r + 32'd1) : mag_r;

  assign udiv_q = A / b_safe;
  assign udiv_r = A % b_safe;

  // ---------------------------------------------------------------------
  // Next-state and datapath update logic.
  // ---------------------------------------------------------------------
  // Decide the next state, counter, pending result and HI/LO each cycle.
  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    hi_next        = hi_reg;
    lo_next        = lo_reg;
    pend_hi_next   = pend_hi_reg;
    pend_lo_next   = pend_lo_reg;
    commit_en_next = commit_en_reg;

    case (state_reg)
      IDLE: begin
        if (MD_start) begin
          case (MD_op)
            OP_MULT: begin
              pend_hi_next   = prod_signed[63:32];
              pend_lo_next   = prod_signed[31:0];
              commit_en_next = 1'b1;
              cnt_next       = MULT_LOAD;
              state_next     = RUN;
            end
            OP_MULTU: begin
              pend_hi_next   = prod_unsigned[63:32];
              pend_lo_next   = prod_unsigned[31:0];
              commit_en_next = 1'b1;
              cnt_next       = MULT_LOAD;
              state_next     = RUN;
            end
            OP_DIV: begin
              pend_hi_next   = sdiv_r;
              pend_lo_next   = sdiv_q;
              commit_en_next = ~b_zero;
              cnt_next       = DIV_LOAD;
              state_next     = RUN;
            end
            OP_DIVU: begin
              pend_hi_next   = udiv_r;
              pend_lo_next   = udiv_q;
              commit_en_next = ~b_zero;
              cnt_next       = DIV_LOAD;
              state_next     = RUN;
            end
            // Register moves complete at this edge and never stall.
            OP_MTHI: hi_next = A;
            OP_MTLO: lo_next = A;
            default: ;
          endcase
        end
      end

      RUN: begin
        // New starts are ignored here; the hazard unit prevents them.
        cnt_next = cnt_reg - CNT_ONE;
        if (cnt_reg == CNT_ONE) begin
          state_next     = IDLE;
          commit_en_next = 1'b0;
          if (commit_en_reg) begin
            hi_next = pend_hi_reg;
            lo_next = pend_lo_reg;
          end
        end
      end

      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase

    // Registered busy: high exactly for the cycles spent in RUN.
    busy_next = (state_next == RUN);
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      hi_reg        <= '0;
      lo_reg        <= '0;
      pend_hi_reg   <= '0;
      pend_lo_reg   <= '0;
      commit_en_reg <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      hi_reg        <= hi_next;
      lo_reg        <= lo_next;
      pend_hi_reg   <= pend_hi_next;
      pend_lo_reg   <= pend_lo_next;
      commit_en_reg <= commit_en_next;
      busy_reg      <= busy_next;
    end
  end

  assign busy = busy_reg;
  assign HI   = hi_reg;
  assign LO   = lo_reg;

endmodule
